// File: rtl/wb_commit_arbiter_if.sv
// Bundles the execute-unit result channels and the registered writeback
// stream of one issue slice. The arbiter is the slave, producers/sink the master.
interface wb_commit_arbiter_if #(
   parameter int NUM_INPUTS  = 4,
   parameter int NUM_THREADS = 4,
   parameter int XLEN        = 32,
   parameter int NW_WIDTH    = 2,
   parameter int NR_WIDTH    = 6
);
   // Execute-unit result channels, channel i occupies slice i of each vector
   logic [NUM_INPUTS-1:0]                  in_valid;
   logic [NUM_INPUTS-1:0]                  in_ready;
   logic [NUM_INPUTS*NW_WIDTH-1:0]         in_wid;
   logic [NUM_INPUTS*NUM_THREADS-1:0]      in_tmask;
   logic [NUM_INPUTS*NR_WIDTH-1:0]         in_rd;
   logic [NUM_INPUTS*NUM_THREADS*XLEN-1:0] in_data;
   logic [NUM_INPUTS-1:0]                  in_eop;

   // Writeback stream towards the issue stage (no backpressure)
   logic                                   wb_valid;
   logic [NW_WIDTH-1:0]                    wb_wid;
   logic [NUM_THREADS-1:0]                 wb_tmask;
   logic [NR_WIDTH-1:0]                    wb_rd;
   logic [NUM_THREADS*XLEN-1:0]            wb_data;
   logic                                   wb_eop;

   modport master (
      output in_valid, in_wid, in_tmask, in_rd, in_data, in_eop,
      input  in_ready,
      input  wb_valid, wb_wid, wb_tmask, wb_rd, wb_data, wb_eop
   );

   modport slave (
      input  in_valid, in_wid, in_tmask, in_rd, in_data, in_eop,
      output in_ready,
      output wb_valid, wb_wid, wb_tmask, wb_rd, wb_data, wb_eop
   );
endinterface

// File: rtl/wb_commit_arbiter.sv
// Writeback commit arbiter: round-robin over execute-unit result channels,
// holding the grant on one channel until its end-of-packet beat, and
// presenting the winner on a one-cycle-latency registered writeback stream.
module wb_commit_arbiter #(
   parameter int NUM_INPUTS    = 4,
   parameter int NUM_THREADS   = 4,
   parameter int XLEN          = 32,
   parameter int NW_WIDTH      = 2,
   parameter int NR_WIDTH      = 6,
   parameter int PERF_CTR_BITS = 44
) (
   input  logic                     clk,
   input  logic                     reset,
   wb_commit_arbiter_if.slave       bus,
   output logic [PERF_CTR_BITS-1:0] perf_stalls
);
   localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int DW    = NUM_THREADS * XLEN;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

   // Arbitration state
   logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic                     lock_q, lock_d;
   logic [IDX_W-1:0]         lock_idx_q, lock_idx_d;
   logic [PERF_CTR_BITS-1:0] perf_q, perf_d;

   // Writeback output register
   logic                     wb_valid_q, wb_valid_d;
   logic [NW_WIDTH-1:0]      wb_wid_q, wb_wid_d;
   logic [NUM_THREADS-1:0]   wb_tmask_q, wb_tmask_d;
   logic [NR_WIDTH-1:0]      wb_rd_q, wb_rd_d;
   logic [DW-1:0]            wb_data_q, wb_data_d;
   logic                     wb_eop_q, wb_eop_d;

   // Combinational grant and selected-channel fields
   logic [IDX_W-1:0]         grant_idx;
   logic                     grant_valid;
   logic [NUM_INPUTS-1:0]    ready_vec;
   logic                     fire;
   logic                     stall;
   logic [NW_WIDTH-1:0]      sel_wid;
   logic [NUM_THREADS-1:0]   sel_tmask;
   logic [NR_WIDTH-1:0]      sel_rd;
   logic [DW-1:0]            sel_data;
   logic                     sel_eop;
   int                       cand;

   // Pick the winner: locked channel only, else first valid after rr_ptr
   always_comb begin
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = 0;
      if (lock_q) begin
         grant_idx   = lock_idx_q;
         grant_valid = bus.in_valid[lock_idx_q];
      end else begin
         for (int k = 1; k <= NUM_INPUTS; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_INPUTS;
            if (!grant_valid && bus.in_valid[IDX_W'(cand)]) begin
               grant_valid = 1'b1;
               grant_idx   = IDX_W'(cand);
            end
         end
      end
   end

   // One-hot ready; a single channel is a plain pass-through, always ready
   always_comb begin
      ready_vec = '0;
      if (NUM_INPUTS == 1) begin
         ready_vec = '1;
      end else if (grant_valid) begin
         ready_vec[grant_idx] = 1'b1;
      end
   end

   assign bus.in_ready = ready_vec;
   assign fire         = |(bus.in_valid & ready_vec);
   assign stall        = |(bus.in_valid & ~ready_vec);

   // Mux the granted channel's fields out of the flattened input vectors
   always_comb begin
      sel_wid   = '0;
      sel_tmask = '0;
      sel_rd    = '0;
      sel_data  = '0;
      sel_eop   = 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (grant_idx == IDX_W'(i)) begin
            sel_wid   = bus.in_wid[i*NW_WIDTH +: NW_WIDTH];
            sel_tmask = bus.in_tmask[i*NUM_THREADS +: NUM_THREADS];
            sel_rd    = bus.in_rd[i*NR_WIDTH +: NR_WIDTH];
            sel_data  = bus.in_data[i*DW +: DW];
            sel_eop   = bus.in_eop[i];
         end
      end
   end

   // Next state: lock on a non-eop beat, release and move rr_ptr on eop
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      perf_d     = perf_q + PERF_CTR_BITS'(stall);
      wb_valid_d = fire;
      wb_wid_d   = wb_wid_q;
      wb_tmask_d = wb_tmask_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      wb_eop_d   = wb_eop_q;
      if (fire) begin
         wb_wid_d   = sel_wid;
         wb_tmask_d = sel_tmask;
         wb_rd_d    = sel_rd;
         wb_data_d  = sel_data;
         wb_eop_d   = sel_eop;
         if (sel_eop) begin
            rr_ptr_d = grant_idx;
            lock_d   = 1'b0;
         end else begin
            lock_d     = 1'b1;
            lock_idx_d = grant_idx;
         end
      end
   end

   // State and output registers; reset drops any partially delivered packet
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q   <= LAST_IDX;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         perf_q     <= '0;
         wb_valid_q <= 1'b0;
         wb_wid_q   <= '0;
         wb_tmask_q <= '0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         wb_eop_q   <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         perf_q     <= perf_d;
         wb_valid_q <= wb_valid_d;
         wb_wid_q   <= wb_wid_d;
         wb_tmask_q <= wb_tmask_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         wb_eop_q   <= wb_eop_d;
      end
   end

   assign bus.wb_valid = wb_valid_q;
   assign bus.wb_wid   = wb_wid_q;
   assign bus.wb_tmask = wb_tmask_q;
   assign bus.wb_rd    = wb_rd_q;
   assign bus.wb_data  = wb_data_q;
   assign bus.wb_eop   = wb_eop_q;
   assign perf_stalls  = perf_q;
endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Directed bench for wb_commit_arbiter: a 4-channel instance for arbitration,
// locking, reset and stall counting, plus a 1-channel pass-through instance.
`timescale 1ns/1ps
module tb_wb_commit_arbiter;
   localparam int NI = 4;
   localparam int NT = 4;
   localparam int XL = 32;
   localparam int NW = 2;
   localparam int NR = 6;
   localparam int PB = 44;

   logic          clk = 1'b0;
   logic          reset;
   logic [PB-1:0] perf;
   logic [PB-1:0] perf1;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   wb_commit_arbiter_if #(.NUM_INPUTS(NI), .NUM_THREADS(NT), .XLEN(XL),
                          .NW_WIDTH(NW), .NR_WIDTH(NR)) bus ();
   wb_commit_arbiter_if #(.NUM_INPUTS(1), .NUM_THREADS(NT), .XLEN(XL),
                          .NW_WIDTH(NW), .NR_WIDTH(NR)) bus1 ();

   wb_commit_arbiter #(.NUM_INPUTS(NI), .NUM_THREADS(NT), .XLEN(XL),
                       .NW_WIDTH(NW), .NR_WIDTH(NR), .PERF_CTR_BITS(PB)) dut (
      .clk(clk), .reset(reset), .bus(bus), .perf_stalls(perf));

   wb_commit_arbiter #(.NUM_INPUTS(1), .NUM_THREADS(NT), .XLEN(XL),
                       .NW_WIDTH(NW), .NR_WIDTH(NR), .PERF_CTR_BITS(PB)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1), .perf_stalls(perf1));

   // One line per writeback beat from either instance
   always @(negedge clk) begin
      if (!reset && bus.wb_valid)
         $display("wb4: wid=%0d rd=%0d tmask=%b eop=%0b lane0=%h",
                  bus.wb_wid, bus.wb_rd, bus.wb_tmask, bus.wb_eop, bus.wb_data[31:0]);
      if (!reset && bus1.wb_valid)
         $display("wb1: wid=%0d rd=%0d eop=%0b lane0=%h",
                  bus1.wb_wid, bus1.wb_rd, bus1.wb_eop, bus1.wb_data[31:0]);
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int ch, input logic [NW-1:0] wid, input logic [NT-1:0] tm,
                        input logic [NR-1:0] rd, input logic [XL-1:0] d0, input logic eop);
      bus.in_valid[ch]              = 1'b1;
      bus.in_wid[ch*NW +: NW]       = wid;
      bus.in_tmask[ch*NT +: NT]     = tm;
      bus.in_rd[ch*NR +: NR]        = rd;
      bus.in_eop[ch]                = eop;
      for (int j = 0; j < NT; j++)
         bus.in_data[(ch*NT+j)*XL +: XL] = d0 + XL'(j * 16);
   endtask

   task automatic beat(input int ch, input logic [NR-1:0] rd, input logic eop);
      drive(ch, NW'(ch), 4'hF, rd, 32'h1000 + XL'(rd), eop);
   endtask

   task automatic idle(input int ch);
      bus.in_valid[ch] = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      bus.in_valid   = '0;
      bus.in_wid     = '0;
      bus.in_tmask   = '0;
      bus.in_rd      = '0;
      bus.in_data    = '0;
      bus.in_eop     = '0;
      bus1.in_valid  = '0;
      bus1.in_wid    = '0;
      bus1.in_tmask  = '0;
      bus1.in_rd     = '0;
      bus1.in_data   = '0;
      bus1.in_eop    = '0;
      repeat (3) step();
      reset = 1'b0;

      // Reset state
      check("rst_wb_valid", bus.wb_valid, 1'b0);
      check("rst_wb_rd",    bus.wb_rd, 6'd0);
      check("rst_wb_data",  bus.wb_data, 128'd0);
      check("rst_perf",     perf, 44'd0);

      // All four channels valid with eop: strict rotation 0,1,2,3,...
      for (int c = 0; c < NI; c++) beat(c, NR'(10 + c), 1'b1);
      for (int k = 0; k < 8; k++) begin
         #1;
         check("rr_ready", bus.in_ready, 128'(1) << (k % 4));
         step();
         check("rr_wb_valid", bus.wb_valid, 1'b1);
         check("rr_wb_rd", bus.wb_rd, 128'(10 + (k % 4)));
      end
      check("rr_perf", perf, 44'd8);
      for (int c = 0; c < NI; c++) idle(c);
      step();
      check("rr_idle_valid", bus.wb_valid, 1'b0);

      // Single beat on channel 2 with distinct fields
      drive(2, 2'd1, 4'b1011, 6'd5, 32'hDEADBEEF, 1'b1);
      #1 check("single_ready", bus.in_ready, 4'b0100);
      step();
      check("single_valid", bus.wb_valid, 1'b1);
      check("single_data",  bus.wb_data[31:0], 32'hDEADBEEF);
      check("single_rd",    bus.wb_rd, 6'd5);
      check("single_wid",   bus.wb_wid, 2'd1);
      check("single_tmask", bus.wb_tmask, 4'b1011);
      idle(2);
      step();
      check("single_after", bus.wb_valid, 1'b0);

      // Move rr_ptr to 0 so channel 1 wins the next contest
      beat(0, 6'd30, 1'b1);
      #1 check("pre_ready", bus.in_ready, 4'b0001);
      step();
      idle(0);
      step();

      // Channel 1 three-beat packet with a gap; channel 0 waits throughout
      beat(0, 6'd20, 1'b1);
      beat(1, 6'd21, 1'b0);
      #1 check("lock_a_ready", bus.in_ready, 4'b0010);
      step();
      check("lock_a_rd",  bus.wb_rd, 6'd21);
      check("lock_a_eop", bus.wb_eop, 1'b0);
      beat(1, 6'd22, 1'b0);
      #1 check("lock_b_ready", bus.in_ready, 4'b0010);
      step();
      check("lock_b_rd", bus.wb_rd, 6'd22);
      idle(1);
      #1 check("lock_gap_ready", bus.in_ready, 4'b0000);
      step();
      check("lock_bubble", bus.wb_valid, 1'b0);
      beat(1, 6'd23, 1'b1);
      #1 check("lock_d_ready", bus.in_ready, 4'b0010);
      step();
      check("lock_d_rd",  bus.wb_rd, 6'd23);
      check("lock_d_eop", bus.wb_eop, 1'b1);
      beat(1, 6'd24, 1'b1);
      #1 check("lock_e_ready", bus.in_ready, 4'b0001);
      step();
      check("lock_e_rd", bus.wb_rd, 6'd20);
      idle(0);
      #1 check("lock_f_ready", bus.in_ready, 4'b0010);
      step();
      check("lock_f_rd", bus.wb_rd, 6'd24);
      check("lock_perf", perf, 44'd13);
      idle(1);
      step();

      // Wraparound: rr_ptr=3, channels 0 and 3 contend
      beat(3, 6'd40, 1'b1);
      #1 check("wrap_pre_ready", bus.in_ready, 4'b1000);
      step();
      beat(0, 6'd41, 1'b1);
      beat(3, 6'd42, 1'b1);
      #1 check("wrap_ready0", bus.in_ready, 4'b0001);
      step();
      check("wrap_rd0", bus.wb_rd, 6'd41);
      check("wrap_perf", perf, 44'd14);
      idle(0);
      #1 check("wrap_ready3", bus.in_ready, 4'b1000);
      step();
      check("wrap_rd3", bus.wb_rd, 6'd42);
      check("wrap_perf2", perf, 44'd14);
      idle(3);
      step();

      // Reset while locked on channel 2
      beat(2, 6'd50, 1'b0);
      #1 check("rl_ready", bus.in_ready, 4'b0100);
      step();
      check("rl_rd", bus.wb_rd, 6'd50);
      reset = 1'b1;
      idle(2);
      step();
      check("rl_wb_valid", bus.wb_valid, 1'b0);
      check("rl_perf", perf, 44'd0);
      reset = 1'b0;
      beat(0, 6'd51, 1'b1);
      beat(2, 6'd52, 1'b1);
      #1 check("rl_ready0", bus.in_ready, 4'b0001);
      step();
      check("rl_rd0", bus.wb_rd, 6'd51);
      check("rl_perf1", perf, 44'd1);
      idle(0);
      #1 check("rl_ready2", bus.in_ready, 4'b0100);
      step();
      check("rl_rd2", bus.wb_rd, 6'd52);
      idle(2);
      step();

      // Single-channel build: registered pass-through
      for (int k = 0; k < 5; k++) begin
         bus1.in_valid = 1'b1;
         bus1.in_rd    = NR'(k + 1);
         bus1.in_wid   = NW'(k);
         bus1.in_eop   = 1'b1;
         bus1.in_data  = {NT{32'hA5A50000 + XL'(k)}};
         #1 check("one_ready", bus1.in_ready, 1'b1);
         step();
         check("one_valid", bus1.wb_valid, 1'b1);
         check("one_rd", bus1.wb_rd, 128'(k + 1));
      end
      bus1.in_valid = 1'b0;
      step();
      check("one_after", bus1.wb_valid, 1'b0);
      check("one_perf", perf1, 44'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
